// File: rtl/tile_game_ctrl.sv
// tile_game_ctrl: game sequencer for the piano-tiles display.
// Holds the 4-row tile pattern and the incoming row, scrolls once per frame, judges key
// presses against the bottom row, and keeps score and level speed.
//
// Ports:
//   pixel_clk        sole clock
//   Reset            synchronous, active-high reset
//   frame_tick_i     one-cycle pulse per frame
//   keycode_i        current USB keycode, 0 = none
//   random_i         free-running LFSR value, picks the next incoming column
//   tiles_flat_o     row r (0 = top, 3 = bottom) at bits [5r+4:5r], one-hot column
//   incoming_o       one-hot row entering above row 0
//   scroll_offset_o  pixel offset 0..119
//   hit_row3_o       bottom tile already hit this period
//   error_o          miss / wrong-key indication
//   score_o          hit count, saturates at 1023
//   game_over_o      high in OVER
//   state_o          IDLE=0, PLAY=1, MISS=2, OVER=3
module tile_game_ctrl #(
    parameter int unsigned SPEED_INIT  = 1,
    parameter int unsigned SPEED_MAX   = 6,
    parameter int unsigned LEVEL_HITS  = 8,
    parameter int unsigned MISS_FRAMES = 60
) (
    input  logic        pixel_clk,
    input  logic        Reset,
    input  logic        frame_tick_i,
    input  logic [7:0]  keycode_i,
    input  logic [2:0]  random_i,
    output logic [19:0] tiles_flat_o,
    output logic [4:0]  incoming_o,
    output logic [6:0]  scroll_offset_o,
    output logic        hit_row3_o,
    output logic        error_o,
    output logic [9:0]  score_o,
    output logic        game_over_o,
    output logic [1:0]  state_o
);
    localparam int unsigned LvlW  = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;
    localparam int unsigned MissW = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [6:0]  RowPeriod    = 7'd120;
    localparam logic [19:0] TilesInit    = {5'b00010, 5'b00100, 5'b01000, 5'b10000};
    localparam logic [4:0]  IncomingInit = 5'b00001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StMiss = 2'd2,
        StOver = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [19:0]      tiles_q, tiles_d;
    logic [4:0]       incoming_q, incoming_d;
    logic [6:0]       offset_q, offset_d;
    logic [2:0]       speed_q, speed_d;
    logic [LvlW-1:0]  lvl_cnt_q, lvl_cnt_d;
    logic [MissW-1:0] miss_cnt_q, miss_cnt_d;
    logic [9:0]       score_q, score_d;
    logic             hit_q, hit_d;
    logic             error_q, error_d;
    logic             armed_q, armed_d;
    logic [7:0]       key_prev_q;

    logic       key_new;
    logic [4:0] key_col;
    logic [4:0] rand_col;
    logic [7:0] sum;
    logic       hit;
    logic       wrong;

    assign key_new = (keycode_i != 8'h00) && (keycode_i != key_prev_q);

    always_comb begin
        case (keycode_i)
            8'h07:   key_col = 5'b00001;
            8'h09:   key_col = 5'b00010;
            8'h2C:   key_col = 5'b00100;
            8'h0D:   key_col = 5'b01000;
            8'h0E:   key_col = 5'b10000;
            default: key_col = 5'b00000;
        endcase
    end

    // random mod 5, so 5/6/7 fold onto columns 0/1/2
    always_comb begin
        case (random_i)
            3'd0, 3'd5: rand_col = 5'b00001;
            3'd1, 3'd6: rand_col = 5'b00010;
            3'd2, 3'd7: rand_col = 5'b00100;
            3'd3:       rand_col = 5'b01000;
            default:    rand_col = 5'b10000;
        endcase
    end

    assign sum = {1'b0, offset_q} + {5'b00000, speed_q};

    // Row 3 occupies the top slice; an unmapped key has key_col == 0 and so never hits.
    assign hit   = key_new && armed_q && ((key_col & tiles_q[19:15]) != 5'b00000);
    assign wrong = key_new && armed_q && !hit;

    always_comb begin
        state_d    = state_q;
        tiles_d    = tiles_q;
        incoming_d = incoming_q;
        offset_d   = offset_q;
        speed_d    = speed_q;
        lvl_cnt_d  = lvl_cnt_q;
        miss_cnt_d = miss_cnt_q;
        score_d    = score_q;
        hit_d      = hit_q;
        error_d    = error_q;
        armed_d    = armed_q;

        unique case (state_q)
            StIdle: begin
                if (key_new) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (wrong) begin
                    // A wrong key freezes motion even if a frame tick lands this cycle.
                    error_d    = 1'b1;
                    state_d    = StMiss;
                    miss_cnt_d = '0;
                end else begin
                    if (hit) begin
                        if (score_q != 10'h3FF) begin
                            score_d = score_q + 10'd1;
                        end
                        hit_d   = 1'b1;
                        armed_d = 1'b0;
                        if (lvl_cnt_q == LvlW'(LEVEL_HITS - 1)) begin
                            lvl_cnt_d = '0;
                            if (speed_q < 3'(SPEED_MAX)) begin
                                speed_d = speed_q + 3'd1;
                            end
                        end else begin
                            lvl_cnt_d = lvl_cnt_q + LvlW'(1);
                        end
                    end
                    if (frame_tick_i) begin
                        if (sum < 8'd120) begin
                            offset_d = sum[6:0];
                        end else if (armed_q && !hit) begin
                            // Bottom tile scrolled away unplayed.
                            error_d    = 1'b1;
                            state_d    = StMiss;
                            miss_cnt_d = '0;
                        end else begin
                            offset_d   = sum[6:0] - RowPeriod;
                            tiles_d    = {tiles_q[14:0], incoming_q};
                            incoming_d = rand_col;
                            armed_d    = 1'b1;
                            hit_d      = 1'b0;
                        end
                    end
                end
            end
            StMiss: begin
                if (frame_tick_i) begin
                    if (miss_cnt_q == MissW'(MISS_FRAMES - 1)) begin
                        state_d = StOver;
                    end else begin
                        miss_cnt_d = miss_cnt_q + MissW'(1);
                    end
                end
            end
            StOver: begin
                if (key_new) begin
                    state_d    = StIdle;
                    tiles_d    = TilesInit;
                    incoming_d = IncomingInit;
                    offset_d   = '0;
                    speed_d    = 3'(SPEED_INIT);
                    lvl_cnt_d  = '0;
                    miss_cnt_d = '0;
                    score_d    = '0;
                    hit_d      = 1'b0;
                    error_d    = 1'b0;
                    armed_d    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            tiles_q    <= TilesInit;
            incoming_q <= IncomingInit;
            offset_q   <= '0;
            speed_q    <= 3'(SPEED_INIT);
            lvl_cnt_q  <= '0;
            miss_cnt_q <= '0;
            score_q    <= '0;
            hit_q      <= 1'b0;
            error_q    <= 1'b0;
            armed_q    <= 1'b1;
            key_prev_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            tiles_q    <= tiles_d;
            incoming_q <= incoming_d;
            offset_q   <= offset_d;
            speed_q    <= speed_d;
            lvl_cnt_q  <= lvl_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            score_q    <= score_d;
            hit_q      <= hit_d;
            error_q    <= error_d;
            armed_q    <= armed_d;
            key_prev_q <= keycode_i;
        end
    end

    assign tiles_flat_o    = tiles_q;
    assign incoming_o      = incoming_q;
    assign scroll_offset_o = offset_q;
    assign hit_row3_o      = hit_q;
    assign error_o         = error_q;
    assign score_o         = score_q;
    assign game_over_o     = (state_q == StOver);
    assign state_o         = state_q;

endmodule

// File: tb/tb_tile_game_ctrl.sv
// tb_tile_game_ctrl: self-checking bench for tile_game_ctrl.
// Short start-up sequence from a vector table, then hand-written sequences for scrolling,
// miss/over, wrong key, reset during MISS and the level speed-up.
module tb_tile_game_ctrl;
    logic        pixel_clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic [7:0]  keycode;
    logic [2:0]  random;
    logic [19:0] tiles_flat;
    logic [4:0]  incoming;
    logic [6:0]  scroll_offset;
    logic        hit_row3;
    logic        error;
    logic [9:0]  score;
    logic        game_over;
    logic [1:0]  state;

    tile_game_ctrl dut (
        .pixel_clk       (pixel_clk),
        .Reset           (Reset),
        .frame_tick_i    (frame_tick),
        .keycode_i       (keycode),
        .random_i        (random),
        .tiles_flat_o    (tiles_flat),
        .incoming_o      (incoming),
        .scroll_offset_o (scroll_offset),
        .hit_row3_o      (hit_row3),
        .error_o         (error),
        .score_o         (score),
        .game_over_o     (game_over),
        .state_o         (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    localparam logic [4:0]  R0 = 5'b10000;
    localparam logic [4:0]  R1 = 5'b01000;
    localparam logic [4:0]  R2 = 5'b00100;
    localparam logic [4:0]  R3 = 5'b00010;
    localparam logic [4:0]  INC0 = 5'b00001;
    localparam logic [19:0] T_RST = {R3, R2, R1, R0};
    localparam logic [19:0] T_A   = {R2, R1, R0, INC0};

    typedef struct packed {
        logic        tick;
        logic [7:0]  key;
        logic [2:0]  rnd;
        logic [46:0] exp;
    } vec_t;

    vec_t        tbl [10];
    logic [46:0] exp_q [$];
    string       name_q [$];
    int          checks = 0;
    int          failures = 0;

    // Bench-side model of the tile rows for the long hit sequence.
    logic [4:0]  rows [4];
    logic [4:0]  inc_m;
    logic [9:0]  sc_m;

    function automatic logic [46:0] mk(input logic [1:0] st, input logic [9:0] sc,
                                       input logic [6:0] off, input logic [19:0] tl,
                                       input logic [4:0] inc, input logic er, input logic ht);
        return {st, sc, off, tl, inc, er, ht, (st == 2'd3)};
    endfunction

    function automatic logic [7:0] keymap(input logic [4:0] row);
        case (row)
            5'b00001: return 8'h07;
            5'b00010: return 8'h09;
            5'b00100: return 8'h2C;
            5'b01000: return 8'h0D;
            default:  return 8'h0E;
        endcase
    endfunction

    function automatic logic [19:0] model_tiles();
        return {rows[3], rows[2], rows[1], rows[0]};
    endfunction

    task automatic model_shift(input logic [2:0] r);
        rows[3] = rows[2];
        rows[2] = rows[1];
        rows[1] = rows[0];
        rows[0] = inc_m;
        inc_m   = 5'b00001 << (r % 5);
    endtask

    task automatic step(input logic rst, input logic tick, input logic [7:0] key,
                        input logic [2:0] rnd);
        Reset      = rst;
        frame_tick = tick;
        keycode    = key;
        random     = rnd;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check_pop();
        logic [46:0] e;
        logic [46:0] a;
        string       n;
        a = {state, score, scroll_offset, tiles_flat, incoming, error, hit_row3, game_over};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %h required nothing pending", a);
            return;
        end
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got st=%0d sc=%0d off=%0d tiles=%b inc=%b err=%b hit=%b ovr=%b, required st=%0d sc=%0d off=%0d tiles=%b inc=%b err=%b hit=%b ovr=%b",
                     n, a[46:45], a[44:35], a[34:28], a[27:8], a[7:3], a[2], a[1], a[0],
                     e[46:45], e[44:35], e[34:28], e[27:8], e[7:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic step_chk(input logic rst, input logic tick, input logic [7:0] key,
                            input logic [2:0] rnd, input string name, input logic [46:0] e);
        exp_q.push_back(e);
        name_q.push_back(name);
        step(rst, tick, key, rnd);
        check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] k_key;
        logic [2:0] r;

        Reset = 1'b1; frame_tick = 1'b0; keycode = 8'h00; random = 3'd0;
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);

        // Start-up table: start key not judged, hit, held key, disarmed repeat, first tick.
        tbl[0] = '{1'b0, 8'h00, 3'd0, mk(2'd0, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0)};
        tbl[1] = '{1'b0, 8'h07, 3'd0, mk(2'd1, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0)};
        tbl[2] = '{1'b0, 8'h07, 3'd0, mk(2'd1, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0)};
        tbl[3] = '{1'b0, 8'h00, 3'd0, mk(2'd1, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0)};
        tbl[4] = '{1'b0, 8'h09, 3'd0, mk(2'd1, 10'd1, 7'd0, T_RST, INC0, 1'b0, 1'b1)};
        tbl[5] = '{1'b0, 8'h09, 3'd0, mk(2'd1, 10'd1, 7'd0, T_RST, INC0, 1'b0, 1'b1)};
        tbl[6] = '{1'b0, 8'h00, 3'd0, mk(2'd1, 10'd1, 7'd0, T_RST, INC0, 1'b0, 1'b1)};
        tbl[7] = '{1'b0, 8'h09, 3'd0, mk(2'd1, 10'd1, 7'd0, T_RST, INC0, 1'b0, 1'b1)};
        tbl[8] = '{1'b0, 8'h00, 3'd0, mk(2'd1, 10'd1, 7'd0, T_RST, INC0, 1'b0, 1'b1)};
        tbl[9] = '{1'b1, 8'h00, 3'd0, mk(2'd1, 10'd1, 7'd1, T_RST, INC0, 1'b0, 1'b1)};
        for (int i = 0; i < 10; i++) begin
            step_chk(0, tbl[i].tick, tbl[i].key, tbl[i].rnd, $sformatf("vec%0d", i), tbl[i].exp);
        end

        // Scroll to 119, then the 120th tick shifts with offset wrapping to 0.
        for (int i = 0; i < 117; i++) step(0, 1, 8'h00, 0);
        step_chk(0, 1, 8'h00, 0, "off119", mk(2'd1, 10'd1, 7'd119, T_RST, INC0, 1'b0, 1'b1));
        step_chk(0, 1, 8'h00, 3, "shift1", mk(2'd1, 10'd1, 7'd0, T_A, 5'b01000, 1'b0, 1'b0));

        // No key for a full period: miss at the shift tick, tiles frozen.
        for (int i = 0; i < 118; i++) step(0, 1, 8'h00, 0);
        step_chk(0, 1, 8'h00, 0, "pre_miss", mk(2'd1, 10'd1, 7'd119, T_A, 5'b01000, 1'b0, 1'b0));
        step_chk(0, 1, 8'h00, 0, "miss", mk(2'd2, 10'd1, 7'd119, T_A, 5'b01000, 1'b1, 1'b0));
        step_chk(0, 0, 8'h2C, 0, "miss_key", mk(2'd2, 10'd1, 7'd119, T_A, 5'b01000, 1'b1, 1'b0));
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 58; i++) step(0, 1, 8'h00, 0);
        step_chk(0, 1, 8'h00, 0, "miss59", mk(2'd2, 10'd1, 7'd119, T_A, 5'b01000, 1'b1, 1'b0));
        step_chk(0, 1, 8'h00, 0, "over", mk(2'd3, 10'd1, 7'd119, T_A, 5'b01000, 1'b1, 1'b0));
        step_chk(0, 0, 8'h07, 0, "over_key", mk(2'd0, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0));

        // Wrong key while row 3 is column 1.
        step_chk(0, 0, 8'h00, 0, "idle2", mk(2'd0, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0));
        step_chk(0, 0, 8'h07, 0, "start2", mk(2'd1, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0));
        step_chk(0, 0, 8'h0E, 0, "wrong", mk(2'd2, 10'd0, 7'd0, T_RST, INC0, 1'b1, 1'b0));
        step_chk(0, 0, 8'h0E, 0, "wrong_hold", mk(2'd2, 10'd0, 7'd0, T_RST, INC0, 1'b1, 1'b0));

        // Reset in MISS.
        step_chk(1, 0, 8'h00, 0, "rst_miss", mk(2'd0, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0));

        // Eight hits; the third lands on the shift tick itself.
        step_chk(0, 0, 8'h07, 0, "start3", mk(2'd1, 10'd0, 7'd0, T_RST, INC0, 1'b0, 1'b0));
        step(0, 0, 8'h00, 0);
        rows[0] = R0; rows[1] = R1; rows[2] = R2; rows[3] = R3;
        inc_m = INC0;
        sc_m  = 10'd0;
        for (int k = 0; k < 8; k++) begin
            k_key = keymap(rows[3]);
            if (k != 2) begin
                sc_m = sc_m + 10'd1;
                step_chk(0, 0, k_key, 0, $sformatf("lvl_hit%0d", k),
                         mk(2'd1, sc_m, 7'd0, model_tiles(), inc_m, 1'b0, 1'b1));
                step(0, 0, 8'h00, 0);
            end
            if (k < 7) begin
                for (int i = 0; i < 119; i++) step(0, 1, 8'h00, 0);
                r = 3'((3 * k + 5) % 8);
                if (k == 2) sc_m = sc_m + 10'd1;
                model_shift(r);
                step_chk(0, 1, (k == 2) ? k_key : 8'h00, r, $sformatf("lvl_shift%0d", k),
                         mk(2'd1, sc_m, 7'd0, model_tiles(), inc_m, 1'b0, 1'b0));
                step(0, 0, 8'h00, 0);
            end
        end

        // Speed is now 2: 59 ticks reach 118, the next wraps to 0 and shifts.
        for (int i = 0; i < 58; i++) step(0, 1, 8'h00, 0);
        step_chk(0, 1, 8'h00, 0, "spd2_118", mk(2'd1, sc_m, 7'd118, model_tiles(), inc_m, 1'b0, 1'b1));
        model_shift(3'd6);
        step_chk(0, 1, 8'h00, 6, "spd2_wrap", mk(2'd1, sc_m, 7'd0, model_tiles(), inc_m, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
